// File: rtl/fifo_ctrl_pkg.sv
//============================================================================
// Module : fifo_ctrl_pkg
// Purpose: Shared constants and types for the SPRAM-backed FIFO controller.
//          OB_DEPTH : entries in the output buffer queue
//          RD_LAT   : cycles from read issue to the word sitting in the buffer
//          ob_idx_t : index / occupancy type for the output buffer
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package fifo_ctrl_pkg;

  localparam int OB_DEPTH = 3;
  localparam int RD_LAT   = 2;

  // Wide enough to hold an occupancy of 0..OB_DEPTH.
  typedef logic [$clog2(OB_DEPTH+1)-1:0] ob_idx_t;

endpackage

`default_nettype wire

// File: rtl/spram.sv
//============================================================================
// Module : spram
// Purpose: Storage array for the FIFO controller. One write port and one
//          registered read port; the read data register updates on the edge
//          that ends the read-issue cycle.
// Ports  : clk      clock
//          rst_n    async active-low reset (read data register only)
//          i_we     write enable        i_waddr / i_wdata  write address/data
//          i_re     read enable         i_raddr            read address
//          o_rdata  registered read data
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module spram #(
  parameter int WIDTH = 16,
  parameter int SIZE  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [$clog2(SIZE)-1:0] i_waddr,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic                    i_re,
  input  logic [$clog2(SIZE)-1:0] i_raddr,
  output logic [WIDTH-1:0]        o_rdata
);

  logic [WIDTH-1:0] r_mem [SIZE];
  logic [WIDTH-1:0] r_rdata;

  // Array contents are not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/spram_fifo_ctrl.sv
//============================================================================
// Module : spram_fifo_ctrl
// Purpose: FIFO controller built around an spram with registered reads.
//          Words are written into the RAM, read out ahead of demand and
//          parked in a small output buffer so the consumer sees a
//          full-throughput valid/ready stream.
// Ports  : clk, rst (async, active-high), clr (sync flush)
//          in_valid / in_ready / in_data     push side
//          out_valid / out_ready / out_data  pop side (out_data is registered)
//          count                             words held (RAM + in flight + buffer)
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module spram_fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+4)-1:0]   count
);

  localparam int c_AW  = $clog2(DEPTH);
  localparam int c_RCW = $clog2(DEPTH+1);
  localparam int c_CW  = $clog2(DEPTH+4);

  logic [c_AW-1:0]   r_wptr;
  logic [c_AW-1:0]   r_rptr;
  logic [c_RCW-1:0]  r_ram_cnt;
  // Issue is stage 0 (w_ren); this register is the final stage, marking
  // that the spram output register holds a word to capture this cycle.
  logic [RD_LAT-2:0] r_rd_vld;
  ob_idx_t           r_ob_cnt;
  logic [WIDTH-1:0]  r_ob [OB_DEPTH];

  logic              w_push;
  logic              w_pop;
  logic              w_ren;
  logic              w_cap;
  logic [2:0]        w_ob_sum;
  ob_idx_t           w_ob_widx;
  logic [WIDTH-1:0]  w_rdata;
  logic              w_rst_n;

  assign w_rst_n   = ~rst;
  assign in_ready  = !rst && !clr && (r_ram_cnt < c_RCW'(DEPTH));
  assign out_valid = (r_ob_cnt != '0);
  assign out_data  = r_ob[0];

  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_cap     = r_rd_vld[RD_LAT-2];

  // Buffer occupancy after this cycle's pop, counting the word already in
  // flight; a new read may only be issued if it will have a slot to land in.
  // A pop implies r_ob_cnt >= 1, so the subtraction never underflows.
  assign w_ob_sum  = {1'b0, r_ob_cnt} + {2'b00, w_cap} - {2'b00, w_pop};
  assign w_ren     = (r_ram_cnt != '0) && !clr && (w_ob_sum < 3'(OB_DEPTH));

  // Arriving word lands right behind the entries that survive this pop.
  assign w_ob_widx = r_ob_cnt - ob_idx_t'(w_pop);

  assign count = c_CW'(r_ram_cnt) + c_CW'(w_cap) + c_CW'(r_ob_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ram_cnt <= '0;
      r_rd_vld  <= '0;
      r_ob_cnt  <= '0;
      for (int i = 0; i < OB_DEPTH; i++) r_ob[i] <= '0;
    end else if (clr) begin
      // Clearing r_rd_vld drops the word still sitting in the spram output.
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ram_cnt <= '0;
      r_rd_vld  <= '0;
      r_ob_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_ren)  r_rptr <= r_rptr + 1'b1;
      r_ram_cnt <= r_ram_cnt + c_RCW'(w_push) - c_RCW'(w_ren);
      r_rd_vld  <= w_ren;
      r_ob_cnt  <= r_ob_cnt + ob_idx_t'(w_cap) - ob_idx_t'(w_pop);
      if (w_pop) begin
        for (int i = 0; i < OB_DEPTH-1; i++) r_ob[i] <= r_ob[i+1];
      end
      // Placed after the shift so a capture overrides the shifted value.
      if (w_cap && (w_ob_widx < ob_idx_t'(OB_DEPTH))) r_ob[w_ob_widx] <= w_rdata;
    end
  end

  spram #(
    .WIDTH (WIDTH),
    .SIZE  (DEPTH)
  ) u_spram (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (in_data),
    .i_re    (w_ren),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_spram_fifo_ctrl.sv
//============================================================================
// Module : tb_spram_fifo_ctrl
// Purpose: Directed self-checking bench for spram_fifo_ctrl with a queue
//          scoreboard for ordering, occupancy and stall stability.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_spram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [5:0]  count;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] q[$];
  logic        stall_prev = 1'b0;
  logic [15:0] stall_data = '0;
  logic        acc;
  logic [15:0] nxt;
  int          pushed;
  int          budget;

  spram_fifo_ctrl #(.WIDTH(16), .DEPTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then score the
  // handshakes that the next rising edge will perform.
  task automatic cyc(input logic iv, input logic [15:0] d, input logic ordy,
                     input logic iclr, output logic accepted);
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clr       = iclr;
    #1;
    chk("count", 32'(count), 32'(q.size()));
    if (stall_prev) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(stall_data));
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("pop_unexpected", 32'(out_valid), 32'd0);
      else begin
        chk("pop_data", 32'(out_data), 32'(q[0]));
        void'(q.pop_front());
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) q.push_back(d);
    stall_prev = out_valid && !out_ready;
    stall_data = out_data;
    if (iclr) begin
      q.delete();
      stall_prev = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;

    // Single word latency: push in cycle 0, visible in cycle 3.
    cyc(1'b1, 16'h0001, 1'b1, 1'b0, acc);
    chk("lat_accept", 32'(acc), 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
    chk("lat_c1_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
    chk("lat_c2_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
    chk("lat_c3_valid", 32'(out_valid), 32'd1);
    chk("lat_c3_data", 32'(out_data), 32'h0001);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
    chk("lat_c4_count", 32'(count), 32'd0);

    // Fill to capacity with the consumer stalled.
    for (int i = 0; i < 35; i++) begin
      cyc(1'b1, 16'(i), 1'b0, 1'b0, acc);
      chk("fill_accept", 32'(acc), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'h0023, 1'b0, 1'b0, acc);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_count", 32'(count), 32'd35);
    end

    // Release the consumer with continuous pushes; pointers wrap.
    nxt = 16'h0023;
    for (int i = 0; i < 70; i++) begin
      cyc(1'b1, nxt, 1'b1, 1'b0, acc);
      if (acc) nxt++;
      chk("stream_valid", 32'(out_valid), 32'd1);
      if (i == 0) chk("stream_first_in_ready", 32'(in_ready), 32'd0);
      if (i >= 2) chk("stream_count", 32'(count), 32'd34);
    end

    // Random backpressure.
    pushed = 0;
    budget = 0;
    while (pushed < 1000 && budget < 6000) begin
      cyc(1'b1, nxt, 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) begin
        nxt++;
        pushed++;
      end
      budget++;
      chk("rand_count_max", 32'(count <= 6'd35), 32'd1);
    end
    chk("rand_pushed", 32'(pushed), 32'd1000);
    budget = 0;
    while (q.size() > 0 && budget < 100) begin
      cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
      budget++;
    end
    chk("drain_left", 32'(q.size()), 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, acc);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Flush with words in RAM, in flight and in the buffer.
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0C00 + 16'(i), 1'b0, 1'b0, acc);
    chk("pre_clr_valid", 32'(out_valid), 32'd1);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b1, acc);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
    chk("post_clr_valid", 32'(out_valid), 32'd0);
    chk("post_clr_count", 32'(count), 32'd0);
    cyc(1'b1, 16'h0055, 1'b1, 1'b0, acc);
    chk("post_clr_valid2", 32'(out_valid), 32'd0);
    cyc(1'b1, 16'h0066, 1'b1, 1'b0, acc);
    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
      budget++;
    end
    chk("clr_drain_left", 32'(q.size()), 32'd0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'h00A0 + 16'(i), 1'b0, 1'b0, acc);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, acc);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b0, acc);
    chk("beef_accept", 32'(acc), 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
    chk("beef_c1_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
    chk("beef_c2_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
    chk("beef_c3_valid", 32'(out_valid), 32'd1);
    chk("beef_c3_data", 32'(out_data), 32'hBEEF);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, acc);
    chk("beef_c4_count", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
